// File: rtl/eh2_pkg.sv
// ----------------------------------------------------------------------------
// eh2_pkg
// Shared types and sizes for the EH2 LSU DCCM ECC scrub write-back engine.
//   DCCM_BITS        : DCCM byte-address width
//   DCCM_DATA_WIDTH  : data bits per DCCM word
//   DCCM_ECC_WIDTH   : SECDED check bits per word
//   DCCM_FDATA_WIDTH : full stored word width {ecc, data}
//   eh2_scrub_entry_t: one scrub queue entry {valid, word address, data}
//   eh2_scrub_state_t: scrub FSM states (IDLE, ARB, GAP)
// ----------------------------------------------------------------------------
package eh2_pkg;

    localparam int DCCM_BITS        = 16;
    localparam int DCCM_DATA_WIDTH  = 32;
    localparam int DCCM_ECC_WIDTH   = 7;
    localparam int DCCM_FDATA_WIDTH = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;

    typedef struct packed {
        logic                       valid;
        logic [DCCM_BITS-3:0]       waddr;
        logic [DCCM_DATA_WIDTH-1:0] data;
    } eh2_scrub_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARB  = 2'b01,
        GAP  = 2'b10
    } eh2_scrub_state_t;

endpackage

// File: rtl/rvecc_encode.sv
// ----------------------------------------------------------------------------
// rvecc_encode
// EH2 SECDED(39,32) check-bit generator.
//   din     in  32  data word
//   ecc_out out  7  check bits; [5:0] Hamming syndrome bits, [6] overall parity
// ----------------------------------------------------------------------------
module rvecc_encode (
    input  logic [31:0] din,
    output logic [6:0]  ecc_out
);

    // Data bit d sits at Hamming position p (1-based, powers of two skipped);
    // check bit k covers every data bit whose position has bit k set.
    function automatic logic [6:0] secded_gen(input logic [31:0] d);
        logic [6:0] e;
        e[0] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[11]^d[13]^d[15]^d[17]^d[19]^d[21]^d[23]^d[25]^d[26]^d[28]^d[30];
        e[1] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10]^d[12]^d[13]^d[16]^d[17]^d[20]^d[21]^d[24]^d[25]^d[27]^d[28]^d[31];
        e[2] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10]^d[14]^d[15]^d[16]^d[17]^d[22]^d[23]^d[24]^d[25]^d[29]^d[30]^d[31];
        e[3] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[10]^d[18]^d[19]^d[20]^d[21]^d[22]^d[23]^d[24]^d[25];
        e[4] = d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[20]^d[21]^d[22]^d[23]^d[24]^d[25];
        e[5] = d[26]^d[27]^d[28]^d[29]^d[30]^d[31];
        // Overall parity spans data and the six syndrome bits (double-error detect).
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    assign ecc_out = secded_gen(din);

endmodule

// File: rtl/eh2_lsu_ecc_scrub.sv
// ----------------------------------------------------------------------------
// eh2_lsu_ecc_scrub
// DCCM ECC scrub write-back engine. Queues single-bit-error reports from the
// load pipe and writes the corrected word, re-encoded with SECDED, back into
// DCCM in cycles where the DCCM write port is idle.
//
// Build option: RV_ECC_SCRUB_COUNT_EN -- when defined, scrub_wb_count counts
// completed write-backs (saturating); otherwise it is tied to zero.
//
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   err_valid/err_addr/err_data  single-error report (pulse, byte addr, data)
//   st_snoop_valid/st_snoop_addr store/DMA write to DCCM this cycle
//   dccm_idle                  same-cycle grant of the DCCM write port
//   dec_tlu_core_ecc_disable   flush queue and ignore reports
//   scrub_wren/scrub_wr_addr/scrub_wr_data  DCCM write (word addr, {ecc,data})
//   scrub_busy                 queue nonempty or FSM not IDLE
//   err_drop                   registered pulse: a report was lost (queue full)
//   scrub_wb_count             completed write-backs, saturating
// Data/address widths come from eh2_pkg.
// ----------------------------------------------------------------------------
module eh2_lsu_ecc_scrub
    import eh2_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        err_valid,
    input  logic [DCCM_BITS-1:0]        err_addr,
    input  logic [DCCM_DATA_WIDTH-1:0]  err_data,
    input  logic                        st_snoop_valid,
    input  logic [DCCM_BITS-1:0]        st_snoop_addr,
    input  logic                        dccm_idle,
    input  logic                        dec_tlu_core_ecc_disable,
    output logic                        scrub_wren,
    output logic [DCCM_BITS-1:0]        scrub_wr_addr,
    output logic [DCCM_FDATA_WIDTH-1:0] scrub_wr_data,
    output logic                        scrub_busy,
    output logic                        err_drop,
    output logic [15:0]                 scrub_wb_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int AW = DCCM_BITS - 2;

    eh2_scrub_entry_t            queue_r [QDEPTH];
    logic [PW-1:0]               head_r;
    logic [PW-1:0]               tail_r;
    logic [CW-1:0]               cnt_r;
    logic [CW-1:0]               cnt_nxt_s;
    eh2_scrub_state_t            state_r;
    eh2_scrub_state_t            state_nxt_s;
    logic                        err_drop_r;

    eh2_scrub_entry_t            head_s;
    logic [AW-1:0]               err_waddr_s;
    logic [AW-1:0]               snp_waddr_s;
    logic                        head_snoop_s;
    logic                        grant_s;
    logic                        scrub_wren_s;
    logic                        pop_s;
    logic                        push_req_s;
    logic                        snoop_kill_s;
    logic                        coalesce_s;
    logic                        full_s;
    logic                        alloc_s;
    logic                        drop_s;
    logic [QDEPTH-1:0]           coal_hit_s;
    logic [QDEPTH-1:0]           snoop_hit_s;
    logic [DCCM_ECC_WIDTH-1:0]   ecc_s;
    logic                        unused_addr_lsb_s;

    // Byte-offset bits never matter: everything is tracked per word.
    assign unused_addr_lsb_s = ^{err_addr[1:0], st_snoop_addr[1:0]};

    assign err_waddr_s  = err_addr[DCCM_BITS-1:2];
    assign snp_waddr_s  = st_snoop_addr[DCCM_BITS-1:2];
    assign head_s       = queue_r[head_r];
    assign full_s       = (cnt_r == CW'(QDEPTH));
    assign head_snoop_s = st_snoop_valid & head_s.valid & (head_s.waddr == snp_waddr_s);

    // A granted head whose word is overwritten by a store this cycle is
    // popped without writing: the store data is newer than the scrub data.
    assign grant_s      = (state_r == ARB) & ~dec_tlu_core_ecc_disable & head_s.valid & dccm_idle;
    assign scrub_wren_s = grant_s & ~head_snoop_s;
    assign pop_s        = (state_r == ARB) & ~dec_tlu_core_ecc_disable & (cnt_r != {CW{1'b0}})
                        & (~head_s.valid | dccm_idle);

    assign push_req_s   = err_valid & ~dec_tlu_core_ecc_disable;
    assign snoop_kill_s = st_snoop_valid & (snp_waddr_s == err_waddr_s);

    // Per-entry coalesce and snoop matches; the head being written this cycle
    // is excluded from coalescing since its data is already leaving.
    always_comb begin
        coal_hit_s  = {QDEPTH{1'b0}};
        snoop_hit_s = {QDEPTH{1'b0}};
        for (int i = 0; i < QDEPTH; i++) begin
            if (queue_r[i].valid && (queue_r[i].waddr == err_waddr_s) &&
                !(grant_s && (PW'(i) == head_r))) begin
                coal_hit_s[i] = 1'b1;
            end else begin
                coal_hit_s[i] = 1'b0;
            end
            if (st_snoop_valid && queue_r[i].valid && (queue_r[i].waddr == snp_waddr_s)) begin
                snoop_hit_s[i] = 1'b1;
            end else begin
                snoop_hit_s[i] = 1'b0;
            end
        end
    end

    assign coalesce_s = |coal_hit_s;
    // A pop on the same edge frees a slot, so a full queue still accepts.
    assign alloc_s    = push_req_s & ~snoop_kill_s & ~coalesce_s & (~full_s | pop_s);
    assign drop_s     = push_req_s & ~snoop_kill_s & ~coalesce_s & full_s & ~pop_s;
    assign cnt_nxt_s  = cnt_r + {{(CW-1){1'b0}}, alloc_s} - {{(CW-1){1'b0}}, pop_s};

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < QDEPTH; i++) begin
                queue_r[i] <= '0;
            end
            head_r <= {PW{1'b0}};
            tail_r <= {PW{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else if (dec_tlu_core_ecc_disable) begin
            for (int i = 0; i < QDEPTH; i++) begin
                queue_r[i].valid <= 1'b0;
            end
            head_r <= {PW{1'b0}};
            tail_r <= {PW{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (snoop_hit_s[i]) begin
                    queue_r[i].valid <= 1'b0;
                end
                if (coal_hit_s[i] && !snoop_kill_s) begin
                    queue_r[i].data <= err_data;
                end
            end
            if (pop_s) begin
                queue_r[head_r].valid <= 1'b0;
                head_r <= head_r + PW'(1);
            end
            // Allocation comes last so a full-and-pop push into the slot
            // just vacated by the head wins over the pop's valid clear.
            if (alloc_s) begin
                queue_r[tail_r] <= '{valid: 1'b1, waddr: err_waddr_s, data: err_data};
                tail_r <= tail_r + PW'(1);
            end
            cnt_r <= cnt_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (dec_tlu_core_ecc_disable) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        state_nxt_s = ARB;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARB: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_nxt_s = IDLE;
                    end else if (head_s.valid && dccm_idle) begin
                        state_nxt_s = GAP;
                    end else if (!head_s.valid) begin
                        if (cnt_nxt_s == {CW{1'b0}}) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = ARB;
                        end
                    end else begin
                        state_nxt_s = ARB;
                    end
                end
                GAP: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        state_nxt_s = ARB;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Dropped-report pulse, one cycle after the lost report.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_drop_r <= 1'b0;
        end else begin
            err_drop_r <= drop_s;
        end
    end

    rvecc_encode u_ecc (
        .din     (head_s.data),
        .ecc_out (ecc_s)
    );

    // Write port: address/data held at zero when no write is issued.
    always_comb begin
        if (scrub_wren_s) begin
            scrub_wr_addr = {head_s.waddr, 2'b00};
            scrub_wr_data = {ecc_s, head_s.data};
        end else begin
            scrub_wr_addr = {DCCM_BITS{1'b0}};
            scrub_wr_data = {DCCM_FDATA_WIDTH{1'b0}};
        end
    end

    assign scrub_wren = scrub_wren_s;
    assign scrub_busy = (cnt_r != {CW{1'b0}}) | (state_r != IDLE);
    assign err_drop   = err_drop_r;

`ifdef RV_ECC_SCRUB_COUNT_EN
    logic [15:0] wb_count_r;

    // Saturating count of issued write-backs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wb_count_r <= 16'h0000;
        end else if (scrub_wren_s && (wb_count_r != 16'hFFFF)) begin
            wb_count_r <= wb_count_r + 16'h0001;
        end else begin
            wb_count_r <= wb_count_r;
        end
    end

    assign scrub_wb_count = wb_count_r;
`else
    assign scrub_wb_count = 16'h0000;
`endif

endmodule

// File: tb/tb_eh2_lsu_ecc_scrub.sv
// ----------------------------------------------------------------------------
// tb_eh2_lsu_ecc_scrub
// Directed cycle-by-cycle vectors for eh2_lsu_ecc_scrub plus a hand-written
// asynchronous-reset sequence. Each table row gives the inputs for one cycle
// and the outputs expected during that same cycle; the SECDED bits of the
// expected write data come from an independent positional Hamming model.
// ----------------------------------------------------------------------------
module tb_eh2_lsu_ecc_scrub;

`ifdef RV_ECC_SCRUB_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_l;
    logic        err_valid;
    logic [15:0] err_addr;
    logic [31:0] err_data;
    logic        st_snoop_valid;
    logic [15:0] st_snoop_addr;
    logic        dccm_idle;
    logic        dec_tlu_core_ecc_disable;
    logic        scrub_wren;
    logic [15:0] scrub_wr_addr;
    logic [38:0] scrub_wr_data;
    logic        scrub_busy;
    logic        err_drop;
    logic [15:0] scrub_wb_count;

    int n_cmp  = 0;
    int n_fail = 0;

    eh2_lsu_ecc_scrub #(.QDEPTH(4)) dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .err_valid                (err_valid),
        .err_addr                 (err_addr),
        .err_data                 (err_data),
        .st_snoop_valid           (st_snoop_valid),
        .st_snoop_addr            (st_snoop_addr),
        .dccm_idle                (dccm_idle),
        .dec_tlu_core_ecc_disable (dec_tlu_core_ecc_disable),
        .scrub_wren               (scrub_wren),
        .scrub_wr_addr            (scrub_wr_addr),
        .scrub_wr_data            (scrub_wr_data),
        .scrub_busy               (scrub_busy),
        .err_drop                 (err_drop),
        .scrub_wb_count           (scrub_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [15:0] ea;
        logic [31:0] ed;
        logic        sv;
        logic [15:0] sa;
        logic        idle;
        logic        dis;
        logic        x_wren;
        logic [15:0] x_addr;
        logic [31:0] x_data;
        logic        x_busy;
        logic        x_drop;
    } vec_t;

    vec_t vecs[$];

    // Hamming(38,32) by position: powers of two hold check bits, check bit k
    // covers positions with bit k set; bit 6 is overall parity.
    function automatic logic [6:0] model_ecc(input logic [31:0] d);
        logic [6:0] e;
        int di;
        e  = 7'h00;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int k = 0; k < 6; k++) begin
                    if (((pos >> k) & 1) == 1) e[k] = e[k] ^ d[di];
                end
                di++;
            end
        end
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic logic [38:0] full_word(input logic wren, input logic [31:0] d);
        if (wren) return {model_ecc(d), d};
        else      return 39'h0;
    endfunction

    function automatic void add_row(input logic ev, input logic [15:0] ea, input logic [31:0] ed,
                                    input logic sv, input logic [15:0] sa, input logic idle,
                                    input logic dis, input logic x_wren, input logic [15:0] x_addr,
                                    input logic [31:0] x_data, input logic x_busy, input logic x_drop);
        vec_t v;
        v.ev = ev; v.ea = ea; v.ed = ed; v.sv = sv; v.sa = sa; v.idle = idle; v.dis = dis;
        v.x_wren = x_wren; v.x_addr = x_addr; v.x_data = x_data; v.x_busy = x_busy; v.x_drop = x_drop;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        logic [31:0] d;

        // ev  ea       ed            sv  sa       idle dis | wren addr     data          busy drop
        // -- single report, minimum latency
        add_row(1'b1,16'h0104,32'hDEADBEEF,1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0104,32'hDEADBEEF,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        // -- five reports while port busy: 5th dropped, then FIFO drain with gaps
        add_row(1'b1,16'h0400,32'h11110000,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b1,16'h0404,32'h22221111,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b1,16'h0408,32'h33332222,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b1,16'h040C,32'h44443333,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b1,16'h0410,32'h55554444,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b1);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0400,32'h11110000,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0404,32'h22221111,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0408,32'h33332222,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h040C,32'h44443333,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        // -- coalesce: two reports to one word, single write with newer data
        add_row(1'b1,16'h0200,32'hAAAA0001,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b1,16'h0200,32'hBBBB0002,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0200,32'hBBBB0002,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        // -- store snoop (other byte of same word) kills queued entry
        add_row(1'b1,16'h0300,32'hCAFE0300,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b1,16'h0302,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        // -- same-cycle push and snoop to one word: discarded, no drop
        add_row(1'b1,16'h0500,32'h00000005,1'b1,16'h0501,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        // -- snoop on the head in the grant cycle: write suppressed, GAP
        add_row(1'b1,16'h0600,32'h66666666,1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b1,16'h0600,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        // -- ecc disable flushes 3 entries, no write even with port free
        add_row(1'b1,16'h0700,32'h77770000,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b1,16'h0704,32'h77770001,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b1,16'h0708,32'h77770002,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b1, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        // -- full queue and pop on the same edge: push accepted, no drop
        add_row(1'b1,16'h0800,32'hA0A0A0A0,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);
        add_row(1'b1,16'h0804,32'hA1A1A1A1,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b1,16'h0808,32'hA2A2A2A2,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b1,16'h080C,32'hA3A3A3A3,1'b0,16'h0000,1'b0,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b1,16'h0810,32'hA4A4A4A4,1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0800,32'hA0A0A0A0,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0804,32'hA1A1A1A1,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0808,32'hA2A2A2A2,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h080C,32'hA3A3A3A3,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b1,16'h0810,32'hA4A4A4A4,1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b1,1'b0);
        add_row(1'b0,16'h0000,32'h0,       1'b0,16'h0000,1'b1,1'b0, 1'b0,16'h0000,32'h0,       1'b0,1'b0);

        rst_l = 1'b0;
        err_valid = 1'b0; err_addr = 16'h0000; err_data = 32'h0;
        st_snoop_valid = 1'b0; st_snoop_addr = 16'h0000;
        dccm_idle = 1'b0; dec_tlu_core_ecc_disable = 1'b0;

        // Reset state.
        #12;
        check("reset wren",  {63'h0, scrub_wren},     64'h0);
        check("reset addr",  {48'h0, scrub_wr_addr},  64'h0);
        check("reset data",  {25'h0, scrub_wr_data},  64'h0);
        check("reset busy",  {63'h0, scrub_busy},     64'h0);
        check("reset drop",  {63'h0, err_drop},       64'h0);
        check("reset count", {48'h0, scrub_wb_count}, 64'h0);
        rst_l = 1'b1;
        step();

        exp_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            err_valid                = vecs[i].ev;
            err_addr                 = vecs[i].ea;
            err_data                 = vecs[i].ed;
            st_snoop_valid           = vecs[i].sv;
            st_snoop_addr            = vecs[i].sa;
            dccm_idle                = vecs[i].idle;
            dec_tlu_core_ecc_disable = vecs[i].dis;
            @(negedge clk);
            check($sformatf("row%0d wren", i), {63'h0, scrub_wren},    {63'h0, vecs[i].x_wren});
            check($sformatf("row%0d addr", i), {48'h0, scrub_wr_addr}, {48'h0, vecs[i].x_addr});
            check($sformatf("row%0d data", i), {25'h0, scrub_wr_data},
                  {25'h0, full_word(vecs[i].x_wren, vecs[i].x_data)});
            check($sformatf("row%0d busy", i), {63'h0, scrub_busy},    {63'h0, vecs[i].x_busy});
            check($sformatf("row%0d drop", i), {63'h0, err_drop},      {63'h0, vecs[i].x_drop});
            check($sformatf("row%0d count", i), {48'h0, scrub_wb_count},
                  CNT_EN ? 64'(exp_cnt) : 64'h0);
            if (vecs[i].x_wren) exp_cnt++;
            step();
        end

        // Asynchronous reset in the middle of a write.
        err_valid = 1'b1; err_addr = 16'h0900; err_data = 32'h12345678;
        st_snoop_valid = 1'b0; dccm_idle = 1'b1; dec_tlu_core_ecc_disable = 1'b0;
        step();
        err_valid = 1'b0;
        step();
        @(negedge clk);
        d = 32'h12345678;
        check("prerst wren",  {63'h0, scrub_wren},     64'h1);
        check("prerst addr",  {48'h0, scrub_wr_addr},  64'h0900);
        check("prerst data",  {25'h0, scrub_wr_data},  {25'h0, full_word(1'b1, d)});
        check("prerst count", {48'h0, scrub_wb_count}, CNT_EN ? 64'(exp_cnt) : 64'h0);
        #1 rst_l = 1'b0;
        #1;
        check("asyncrst wren",  {63'h0, scrub_wren},     64'h0);
        check("asyncrst busy",  {63'h0, scrub_busy},     64'h0);
        check("asyncrst addr",  {48'h0, scrub_wr_addr},  64'h0);
        check("asyncrst count", {48'h0, scrub_wb_count}, 64'h0);
        #1 rst_l = 1'b1;
        step();
        @(negedge clk);
        check("postrst wren", {63'h0, scrub_wren}, 64'h0);
        check("postrst busy", {63'h0, scrub_busy}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
